// File: rtl/ql_pkg.sv
// Shared encodings and counter widths for the QL clock-enable generator.
package ql_pkg;

    localparam logic [1:0] SPD_NORMAL = 2'd0;
    localparam logic [1:0] SPD_X2     = 2'd1;
    localparam logic [1:0] SPD_X4     = 2'd2;

    localparam logic [1:0] RAM_128K   = 2'd0;
    localparam logic [1:0] RAM_640K   = 2'd1;
    localparam logic [1:0] RAM_896K   = 2'd2;

    localparam int DIV_W     = 5;
    // Wide enough for DIV131K_MAX values up to 1023.
    localparam int DIV131K_W = 10;
    localparam int RCNT_W    = 12;

endpackage

// File: rtl/ql_reset_seq.sv
// Stretches the incoming reset request by RST_CYCLES bus strobes and
// latches the RAM configuration while the stretched reset is active.
module ql_reset_seq
    import ql_pkg::*;
#(
    parameter int RST_CYCLES = 4095
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_bus_p,
    input  logic [1:0] ram_sel,
    output logic       sys_reset,
    output logic [1:0] ram_cfg
);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [1:0]        ram_cfg_q;

    always_comb begin
        rcnt_d = rcnt_q;
        if (ce_bus_p && (rcnt_q != '0)) begin
            rcnt_d = rcnt_q - RCNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rcnt_q    <= RCNT_W'(RST_CYCLES);
            ram_cfg_q <= ram_sel;
        end else begin
            rcnt_q <= rcnt_d;
            if (rcnt_q != '0) begin
                ram_cfg_q <= ram_sel;
            end
        end
    end

    assign sys_reset = (rcnt_q != '0);
    assign ram_cfg   = ram_cfg_q;

endmodule

// File: rtl/ql_clkgen.sv
// Clock-enable generator for the QL core: bus/video/SD strobes, the 131 kHz
// RTC tick and speed gating, plus the stretched system reset.
module ql_clkgen
    import ql_pkg::*;
#(
    parameter int RST_CYCLES  = 4095,
    parameter int DIV131K_MAX = 640
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic [1:0] ram_sel,
    output logic       ce_p,
    output logic       ce_n,
    output logic       ce_vid,
    output logic       ce_sd,
    output logic       ce_131k,
    output logic       duty_cycle,
    output logic       sub_cycle,
    output logic       ce_bus_p,
    output logic       ce_bus_n,
    output logic       cpu_cycle,
    output logic       sys_reset,
    output logic [1:0] ram_cfg
);

    localparam logic [DIV131K_W-1:0] DIV131K_TC = DIV131K_W'(DIV131K_MAX);

    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV131K_W-1:0] div131k_q, div131k_d;
    logic [1:0]           spd_q, spd_d;
    logic                 duty_q, duty_d;
    logic                 sub_q, sub_d;
    logic                 ce_p_q, ce_n_q, ce_vid_q, ce_sd_q, ce_131k_q;

    always_comb begin
        div_d     = div_q + DIV_W'(1);
        div131k_d = (div131k_q == DIV131K_TC) ? '0 : div131k_q + DIV131K_W'(1);
        // Speed is only sampled at the end of a 32-clock window.
        spd_d     = (div_q == '1) ? speed : spd_q;
        duty_d    = duty_q;
        if (div_q[2:0] == 3'd0) begin
            case (spd_q)
                SPD_NORMAL: duty_d = (div_q[4:3] == 2'd0);
                SPD_X2:     duty_d = ~div_q[3];
                default:    duty_d = 1'b1;
            endcase
        end
        sub_d = sub_q;
        if (div_q == '0) begin
            sub_d = ~sub_q | (spd_q != SPD_NORMAL);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q     <= '0;
            div131k_q <= '0;
            spd_q     <= speed;
            duty_q    <= 1'b0;
            sub_q     <= 1'b0;
            ce_p_q    <= 1'b0;
            ce_n_q    <= 1'b0;
            ce_vid_q  <= 1'b0;
            ce_sd_q   <= 1'b0;
            ce_131k_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            div131k_q <= div131k_d;
            spd_q     <= spd_d;
            duty_q    <= duty_d;
            sub_q     <= sub_d;
            ce_p_q    <= (div_q[2:0] == 3'd0);
            ce_n_q    <= (div_q[2:0] == 3'd4);
            ce_vid_q  <= (div_q[2:0] == 3'd0);
            ce_sd_q   <= (div_q[1:0] == 2'd0);
            ce_131k_q <= (div131k_q == '0);
        end
    end

    assign ce_p       = ce_p_q;
    assign ce_n       = ce_n_q;
    assign ce_vid     = ce_vid_q;
    assign ce_sd      = ce_sd_q;
    assign ce_131k    = ce_131k_q;
    assign duty_cycle = duty_q;
    assign sub_cycle  = sub_q;
    assign ce_bus_p   = duty_q & ce_p_q;
    assign ce_bus_n   = duty_q & ce_n_q;
    assign cpu_cycle  = duty_q & sub_q;

    ql_reset_seq #(
        .RST_CYCLES (RST_CYCLES)
    ) u_reset_seq (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_bus_p  (ce_bus_p),
        .ram_sel   (ram_sel),
        .sys_reset (sys_reset),
        .ram_cfg   (ram_cfg)
    );

endmodule

// File: tb/tb_ql_clkgen.sv
// Directed bench for ql_clkgen: strobe-rate table plus hand-written
// sequences for speed switching, RTC spacing, reset stretch and RAM latch.
module tb_ql_clkgen;
    import ql_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] speed   = 2'd0;
    logic [1:0] ram_sel = 2'd0;
    logic       ce_p, ce_n, ce_vid, ce_sd, ce_131k;
    logic       duty_cycle, sub_cycle, ce_bus_p, ce_bus_n, cpu_cycle;
    logic       sys_reset;
    logic [1:0] ram_cfg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int         spd;
        int         n;
        int         e_p;
        int         e_n;
        int         e_sd;
        int         e_131k;
        int         e_bp;
        int         e_bn;
        int         e_cpu;
        logic [9:0] e_win;
    } vec_t;

    vec_t vecs[4];

    ql_clkgen #(
        .RST_CYCLES  (4),
        .DIV131K_MAX (640)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .speed      (speed),
        .ram_sel    (ram_sel),
        .ce_p       (ce_p),
        .ce_n       (ce_n),
        .ce_vid     (ce_vid),
        .ce_sd      (ce_sd),
        .ce_131k    (ce_131k),
        .duty_cycle (duty_cycle),
        .sub_cycle  (sub_cycle),
        .ce_bus_p   (ce_bus_p),
        .ce_bus_n   (ce_bus_n),
        .cpu_cycle  (cpu_cycle),
        .sys_reset  (sys_reset),
        .ram_cfg    (ram_cfg)
    );

    // Clock and watchdog.
    always #5 clk_sys = ~clk_sys;

    initial begin
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Holds reset for a few clocks; the next step() is clock 1 after release.
    task automatic do_reset(input logic [1:0] spd, input logic [1:0] ram);
        reset   = 1'b1;
        speed   = spd;
        ram_sel = ram;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic wait_fall(input int budget, output int fall_clk);
        fall_clk = 0;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (!sys_reset) begin
                fall_clk = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int c_p, c_n, c_vid, c_sd, c_131k, c_bp, c_bn, c_cpu, vid_bad, first_n, first_bp;
        logic [9:0] win;
        c_p = 0; c_n = 0; c_vid = 0; c_sd = 0; c_131k = 0; c_bp = 0; c_bn = 0;
        c_cpu = 0; vid_bad = 0; first_n = 0; first_bp = 0; win = '0;
        do_reset(2'(v.spd), RAM_128K);
        for (int k = 1; k <= v.n; k++) begin
            step();
            c_p    += int'(ce_p);
            c_n    += int'(ce_n);
            c_vid  += int'(ce_vid);
            c_sd   += int'(ce_sd);
            c_131k += int'(ce_131k);
            c_bp   += int'(ce_bus_p);
            c_bn   += int'(ce_bus_n);
            c_cpu  += int'(cpu_cycle);
            if (ce_vid != ce_p) vid_bad++;
            if (ce_n && first_n == 0) first_n = k;
            if (ce_bus_p && first_bp == 0) first_bp = k;
            if (cpu_cycle && ((k - 1) / 32) < 10) win[(k - 1) / 32] = 1'b1;
        end
        check($sformatf("spd%0d ce_p", v.spd), c_p, v.e_p);
        check($sformatf("spd%0d ce_n", v.spd), c_n, v.e_n);
        check($sformatf("spd%0d ce_vid", v.spd), c_vid, v.e_p);
        check($sformatf("spd%0d ce_vid_vs_ce_p", v.spd), vid_bad, 0);
        check($sformatf("spd%0d ce_sd", v.spd), c_sd, v.e_sd);
        check($sformatf("spd%0d ce_131k", v.spd), c_131k, v.e_131k);
        check($sformatf("spd%0d ce_bus_p", v.spd), c_bp, v.e_bp);
        check($sformatf("spd%0d ce_bus_n", v.spd), c_bn, v.e_bn);
        check($sformatf("spd%0d cpu_cycle", v.spd), c_cpu, v.e_cpu);
        check($sformatf("spd%0d cpu_windows", v.spd), int'(win), int'(v.e_win));
        check($sformatf("spd%0d first_ce_n", v.spd), first_n, 5);
        check($sformatf("spd%0d first_ce_bus_p", v.spd), first_bp, 1);
    endtask

    // Scoreboard: each ce_bus_p pulse must match the next expected clock.
    task automatic run_speed_seq(input string name, input int chg_clk, input int back_clk);
        do_reset(SPD_NORMAL, RAM_128K);
        for (int k = 1; k <= 64; k++) begin
            step();
            if (ce_bus_p) begin
                if (exp_q.size() == 0) check({name, " extra_pulse"}, k, 0);
                else check({name, " pulse_clk"}, k, int'(exp_q.pop_front()));
            end
            if (k == chg_clk) speed = SPD_X4;
            if (k == back_clk) speed = SPD_NORMAL;
        end
        check({name, " missing_pulses"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int fall_clk, c131, first131, last131, min_gap, max_gap;

        vecs[0] = '{0, 320,  40,  40,  80, 1,  10,  10,   40, 10'b0101010101};
        vecs[1] = '{1, 3200, 400, 400, 800, 5, 200, 200, 1600, 10'h3FF};
        vecs[2] = '{2, 3200, 400, 400, 800, 5, 400, 400, 3200, 10'h3FF};
        vecs[3] = '{3, 320,  40,  40,  80, 1,  40,  40,  320, 10'h3FF};

        // Reset state.
        reset   = 1'b1;
        speed   = SPD_NORMAL;
        ram_sel = RAM_896K;
        repeat (2) step();
        check("rst ce_p", int'(ce_p), 0);
        check("rst ce_n", int'(ce_n), 0);
        check("rst ce_sd", int'(ce_sd), 0);
        check("rst ce_131k", int'(ce_131k), 0);
        check("rst duty_cycle", int'(duty_cycle), 0);
        check("rst sub_cycle", int'(sub_cycle), 0);
        check("rst cpu_cycle", int'(cpu_cycle), 0);
        check("rst sys_reset", int'(sys_reset), 1);
        check("rst ram_cfg", int'(ram_cfg), int'(RAM_896K));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Speed change 0->2 at div=5 takes effect only after the div==31 edge.
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd33);
        exp_q.push_back(8'd41);
        exp_q.push_back(8'd49);
        exp_q.push_back(8'd57);
        run_speed_seq("spdchg", 5, 0);

        // A speed glitch that returns before div==31 has no effect.
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd33);
        run_speed_seq("spdglitch", 5, 20);

        // RTC tick spacing.
        do_reset(SPD_NORMAL, RAM_128K);
        c131 = 0; first131 = 0; last131 = 0; min_gap = 100000; max_gap = 0;
        for (int k = 1; k <= 6410; k++) begin
            step();
            if (ce_131k) begin
                if (c131 == 0) first131 = k;
                else begin
                    if (k - last131 < min_gap) min_gap = k - last131;
                    if (k - last131 > max_gap) max_gap = k - last131;
                end
                last131 = k;
                c131++;
            end
        end
        check("rtc count", c131, 10);
        check("rtc first", first131, 1);
        check("rtc min_gap", min_gap, 641);
        check("rtc max_gap", max_gap, 641);

        // Reset stretch with RST_CYCLES=4 at x4 speed.
        do_reset(SPD_X4, RAM_128K);
        wait_fall(200, fall_clk);
        check("stretch fall_clk", fall_clk, 26);

        do_reset(SPD_X4, RAM_128K);
        repeat (19) step();
        check("stretch mid sys_reset", int'(sys_reset), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_fall(200, fall_clk);
        check("stretch restart fall_clk", fall_clk, 26);

        // Mid-window reset emits no partial strobe.
        do_reset(SPD_X4, RAM_128K);
        repeat (13) step();
        reset = 1'b1;
        step();
        check("midrst ce_n", int'(ce_n), 0);
        check("midrst ce_sd", int'(ce_sd), 0);
        check("midrst ce_bus_n", int'(ce_bus_n), 0);
        check("midrst duty_cycle", int'(duty_cycle), 0);
        reset = 1'b0;
        step();
        check("midrst restart ce_bus_p", int'(ce_bus_p), 1);

        // RAM configuration latch.
        do_reset(SPD_X4, RAM_128K);
        step();
        ram_sel = RAM_640K;
        step();
        check("ram follow during stretch", int'(ram_cfg), int'(RAM_640K));
        wait_fall(200, fall_clk);
        check("ram fall seen", fall_clk > 0 ? 1 : 0, 1);
        ram_sel = RAM_896K;
        repeat (10) step();
        check("ram frozen", int'(ram_cfg), int'(RAM_640K));
        reset = 1'b1;
        step();
        check("ram relatch", int'(ram_cfg), int'(RAM_896K));
        reset = 1'b0;
        wait_fall(200, fall_clk);
        check("ram after new reset", int'(ram_cfg), int'(RAM_896K));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
